post_dec_pipe: RTL

- Post-decode pipeline register chain, LD = POST_DEC_LD stages. Stage 0 is execute entry; stage LD-1 is the oldest.
- Holds in-flight micro-instructions and drives them to forward_control.
- Consumes forward_control's per-stage hit flags and selects forwarded operand values into the execute-entry register.
- Detects not-yet-ready forwarding sources, inserts a bubble, and stalls decode.

---
 rtl/post_dec_pipe.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/post_dec_pipe.sv
// -----------------------------------------------------------------------------
// post_dec_pipe
//   Post-decode pipeline register chain. Stage 0 is execute entry, stage LD-1
//   the oldest. In-flight micro-instructions are exposed to forward_control,
//   whose per-stage hit flags pick forwarded operands for the execute-entry
//   register. A hit on a stage whose result is not final yet inserts a bubble
//   and holds decode.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   flush              squash every in-flight instruction
//   dec_valid          dec_miinst is a real instruction
//   dec_miinst         instruction leaving decode
//   dec_{d,s,t}_val    register-file operand values
//   forward_from       per-stage d/s/t hit flags from forward_control
//   stage_result       destination value produced by each stage
//   stage_result_rdy   stage_result[i] is final this cycle
//   dec_ready          decode instruction accepted this cycle
//   post_dec_miinst    stage registers, index 0 youngest
//   exe_{d,s,t}_val    forwarded operands aligned with post_dec_miinst[0]
//   stall_cycles       saturating stall-cycle counter
// -----------------------------------------------------------------------------
package post_dec_pkg;
    // All-zero encoding is the NOP: no register use flags set.
    typedef struct packed {
        logic [7:0]  opcode;
        logic        use_d;
        logic        use_s;
        logic        use_t;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } miinst_t;

    typedef struct packed {
        logic d;
        logic s;
        logic t;
    } fwd_t;

    localparam miinst_t MIINST_NOP = '0;
endpackage

// Per-operand forwarding select: youngest hitting stage wins, and only that
// stage's ready bit decides whether the operand is still pending.
module post_dec_opsel #(
    parameter int LD = 3,
    parameter int W  = 64
) (
    input  logic [LD-1:0]        hit,
    input  logic [LD-1:0][W-1:0] result,
    input  logic [LD-1:0]        rdy,
    input  logic [W-1:0]         reg_val,
    output logic [W-1:0]         val,
    output logic                 pending
);
    logic found;

    always_comb begin
        val     = reg_val;
        pending = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < LD; i++) begin
            if (hit[i] && !found) begin
                found   = 1'b1;
                val     = result[i];
                pending = !rdy[i];
            end
        end
    end
endmodule

module post_dec_pipe
    import post_dec_pkg::*;
#(
    parameter int POST_DEC_LD = 3,
    parameter int W           = 64
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic                          dec_valid,
    input  miinst_t                       dec_miinst,
    input  logic [W-1:0]                  dec_d_val,
    input  logic [W-1:0]                  dec_s_val,
    input  logic [W-1:0]                  dec_t_val,
    input  fwd_t [POST_DEC_LD-1:0]        forward_from,
    input  logic [POST_DEC_LD-1:0][W-1:0] stage_result,
    input  logic [POST_DEC_LD-1:0]        stage_result_rdy,
    output logic                          dec_ready,
    output miinst_t [POST_DEC_LD-1:0]     post_dec_miinst,
    output logic [W-1:0]                  exe_d_val,
    output logic [W-1:0]                  exe_s_val,
    output logic [W-1:0]                  exe_t_val,
    output logic [31:0]                   stall_cycles
);
    localparam int LD   = POST_DEC_LD;
    localparam int NOPS = 3;  // operands d, s, t

    logic [NOPS-1:0][LD-1:0] hit;
    logic [NOPS-1:0][W-1:0]  reg_val;
    logic [NOPS-1:0][W-1:0]  op_val;
    logic [NOPS-1:0]         op_pend;
    logic                    stall;
    logic                    accept;

    assign reg_val[0] = dec_d_val;
    assign reg_val[1] = dec_s_val;
    assign reg_val[2] = dec_t_val;

    // Regroup per-stage flags into per-operand hit vectors.
    for (genvar i = 0; i < LD; i++) begin : g_hit
        assign hit[0][i] = forward_from[i].d;
        assign hit[1][i] = forward_from[i].s;
        assign hit[2][i] = forward_from[i].t;
    end

    for (genvar k = 0; k < NOPS; k++) begin : g_op
        post_dec_opsel #(.LD(LD), .W(W)) u_opsel (
            .hit     (hit[k]),
            .result  (stage_result),
            .rdy     (stage_result_rdy),
            .reg_val (reg_val[k]),
            .val     (op_val[k]),
            .pending (op_pend[k])
        );
    end

    // Flush wins over a hazard, so a flush cycle never counts as a stall.
    assign stall     = dec_valid & ~flush & (|op_pend);
    assign accept    = dec_valid & ~flush & ~stall;
    assign dec_ready = ~stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            post_dec_miinst <= '0;
            exe_d_val       <= '0;
            exe_s_val       <= '0;
            exe_t_val       <= '0;
        end else if (flush) begin
            post_dec_miinst <= '0;
            exe_d_val       <= '0;
            exe_s_val       <= '0;
            exe_t_val       <= '0;
        end else begin
            for (int i = LD - 1; i > 0; i--) begin
                post_dec_miinst[i] <= post_dec_miinst[i-1];
            end
            if (accept) begin
                post_dec_miinst[0] <= dec_miinst;
                exe_d_val          <= op_val[0];
                exe_s_val          <= op_val[1];
                exe_t_val          <= op_val[2];
            end else begin
                // Bubble: lets the producer advance one stage so the
                // recomputed flags can find its final result next cycle.
                post_dec_miinst[0] <= MIINST_NOP;
                exe_d_val          <= '0;
                exe_s_val          <= '0;
                exe_t_val          <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
endmodule
